strassen_mm_sched: RTL
======================

STRASSEN_MM_SCHED -- requirements
Module: strassen_mm_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1023: number of WAIT cycles before abort (used only when STRASSEN_MM_WDOG_EN is defined).
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-low reset (0 = reset).
REQ-004 SHALL have ports req0 / req1  in  1 each  job request from requester 0 / 1, held high until granted.
REQ-005 SHALL have ports mode0 / mode1  in  4 each  requested matrix size; legal values 2, 4 and 8.
REQ-006 SHALL have ports gnt0 / gnt1  out  1 each  one-cycle grant pulse.
REQ-007 SHALL have ports cmp0 / cmp1  out  1 each  one-cycle job-complete pulse.
REQ-008 SHALL have port mm_start  out  1  one-cycle start pulse to the Strassen multiplier.
REQ-009 SHALL have port mm_mode  out  4  latched size for the multiplier, stable from ISSUE until the job ends.
REQ-010 SHALL have port mm_done  in  1  level done from the multiplier; may stay high from the previous job.
REQ-011 SHALL have ports mm_clr (out 1, abort clear pulse), busy (out 1, state != IDLE), owner (out 1, requester of the current/last job), mode_err (out 1, reject pulse) and err (out 1, sticky timeout flag).

Function
REQ-012 SHALL implement the states IDLE, ISSUE, WAIT, REJECT and ABORT; every output SHALL be registered.
REQ-013 IDLE: if neither req is high, SHALL stay in IDLE; otherwise SHALL select one requester; if only one req is high, that requester is selected.
REQ-014 Arbitration SHALL be round-robin when both req are high: the requester not equal to last_owner wins; last_owner SHALL be 1 after reset, so requester 0 wins first.
REQ-015 Valid selection (mode in {2,4,8}) -> next cycle ISSUE: gnt_x=1, mm_start=1, mm_mode=mode_x, owner=x, last_owner=x; then WAIT.
REQ-016 Invalid selection -> next cycle REJECT: gnt_x=1, cmp_x=1, mode_err=1, no mm_start, mm_mode unchanged, last_owner=x; then IDLE.
REQ-017 WAIT: SHALL set a seen_low flag when mm_done=0 is observed; completion SHALL occur on the first cycle with mm_done=1 and seen_low=1. A stale high done SHALL therefore never complete a job.
REQ-018 On completion, cmp_owner SHALL pulse one cycle later, and the block SHALL return to IDLE in that same cycle.
REQ-019 Latency: req sampled in cycle N -> gnt/mm_start in N+1; mm_done qualified in cycle M -> cmp in M+1; next grant no earlier than M+2.
REQ-020 req and mode changes outside IDLE SHALL be ignored; a req still high in IDLE after its grant SHALL count as a new request.
REQ-021 gnt0/gnt1 and cmp0/cmp1 SHALL never be high in the same cycle; at most one job SHALL be outstanding.

Reset
REQ-022 reset=0 at any clock edge, including mid-job, SHALL force IDLE, seen_low=0, last_owner=1 and the watchdog count to 0, and SHALL drive gnt*, cmp*, mm_start, mm_clr, mode_err, err, busy, owner=0 and mm_mode=0. No cmp SHALL be issued for an aborted job.

Configuration
REQ-023 With STRASSEN_MM_WDOG_EN defined, a counter SHALL count WAIT cycles from 1. On reaching TIMEOUT_CYC without completion: enter ABORT, pulse mm_clr and cmp_owner for one cycle, set err (cleared only by reset), then IDLE. If completion and timeout fall in the same cycle, completion wins.
REQ-024 Without STRASSEN_MM_WDOG_EN, there SHALL be no counter and no ABORT state; mm_clr and err SHALL be tied to 0, and WAIT SHALL wait indefinitely.

Verification
REQ-025 reset=0 for 2 cycles mid-WAIT, then 1 -> all outputs 0, state IDLE, no cmp for the aborted job.
REQ-026 req0=1 mode0=4; mm_done low 3 cycles then high -> gnt0 and mm_start=1 one cycle later, mm_mode=4, cmp0 one cycle after done, busy then 0.
REQ-027 req0 and req1 both held high with mode 2 and mode 8 -> grant order 0,1,0,1; owner matches; mm_mode alternates 2/8.
REQ-028 mm_done held high from the previous job through ISSUE -> no cmp until done drops and rises again.
REQ-029 req1=1 mode1=5 -> gnt1, cmp1 and mode_err in the same cycle, mm_start stays 0, next request is served normally.
REQ-030 With STRASSEN_MM_WDOG_EN, TIMEOUT_CYC=16, mm_done stuck 0 -> mm_clr and cmp pulse on WAIT cycle 16 (+1 register), err=1 until reset; without the macro, busy stays 1.

Source files
------------

// File: rtl/strassen_mm_sched.sv
// Two-requester job scheduler for a Strassen matrix multiplier: round-robin grant,
// stale-done filtering, mode rejection. Optional watchdog abort via STRASSEN_MM_WDOG_EN.
module strassen_mm_sched #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] mode0,
  input  logic [3:0] mode1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       cmp0,
  output logic       cmp1,
  output logic       mm_start,
  output logic [3:0] mm_mode,
  input  logic       mm_done,
  output logic       mm_clr,
  output logic       busy,
  output logic       owner,
  output logic       mode_err,
  output logic       err,
  output logic [2:0] fsm_state
);

`ifdef STRASSEN_MM_WDOG_EN
  typedef enum logic [2:0] {IDLE = 3'd0, ISSUE = 3'd1, WAIT = 3'd2, REJECT = 3'd3, ABORT = 3'd4} state_t;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wd_cnt, wd_cnt_n;
  logic          clr_n, err_n, clr_q, err_q;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, ISSUE = 3'd1, WAIT = 3'd2, REJECT = 3'd3} state_t;
`endif

  state_t     state, state_n;
  logic       seen_low, seen_low_n;
  logic       last_owner, last_owner_n;
  logic       owner_n, start_n, mode_err_n, busy_n;
  logic [1:0] gnt_n, cmp_n;
  logic [3:0] mm_mode_n;
  logic       sel;
  logic [3:0] sel_mode;
  logic       sel_valid;

  // Handshake: req is a level held until the one-cycle gnt pulse; a req still
  // high in IDLE afterwards is a new request. cmp pulses once per granted job.
  always_comb begin
    sel       = (req0 && req1) ? ~last_owner : req1;
    sel_mode  = sel ? mode1 : mode0;
    sel_valid = (sel_mode == 4'd2) || (sel_mode == 4'd4) || (sel_mode == 4'd8);
  end

  always_comb begin
    state_n      = state;
    seen_low_n   = seen_low;
    last_owner_n = last_owner;
    owner_n      = owner;
    mm_mode_n    = mm_mode;
    gnt_n        = 2'b00;
    cmp_n        = 2'b00;
    start_n      = 1'b0;
    mode_err_n   = 1'b0;
`ifdef STRASSEN_MM_WDOG_EN
    wd_cnt_n     = '0;
    clr_n        = 1'b0;
    err_n        = err_q;
`endif
    case (state)
      IDLE: begin
        seen_low_n = 1'b0;
        if (req0 || req1) begin
          last_owner_n = sel;
          gnt_n[sel]   = 1'b1;
          if (sel_valid) begin
            state_n   = ISSUE;
            start_n   = 1'b1;
            mm_mode_n = sel_mode;
            owner_n   = sel;
          end else begin
            state_n    = REJECT;
            cmp_n[sel] = 1'b1;
            mode_err_n = 1'b1;
          end
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        // Only a rising done after a low seen in this job counts as completion.
        if (mm_done && seen_low) begin
          state_n      = IDLE;
          cmp_n[owner] = 1'b1;
        end else begin
          if (!mm_done) seen_low_n = 1'b1;
`ifdef STRASSEN_MM_WDOG_EN
          wd_cnt_n = wd_cnt + CW'(1);
          if (wd_cnt == CW'(TIMEOUT_CYC - 1)) begin
            state_n      = ABORT;
            cmp_n[owner] = 1'b1;
            clr_n        = 1'b1;
            err_n        = 1'b1;
          end
`endif
        end
      end
      REJECT: state_n = IDLE;
`ifdef STRASSEN_MM_WDOG_EN
      ABORT: state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      seen_low   <= 1'b0;
      last_owner <= 1'b1;
      owner      <= 1'b0;
      mm_mode    <= 4'd0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      cmp0       <= 1'b0;
      cmp1       <= 1'b0;
      mm_start   <= 1'b0;
      mode_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      seen_low   <= seen_low_n;
      last_owner <= last_owner_n;
      owner      <= owner_n;
      mm_mode    <= mm_mode_n;
      gnt0       <= gnt_n[0];
      gnt1       <= gnt_n[1];
      cmp0       <= cmp_n[0];
      cmp1       <= cmp_n[1];
      mm_start   <= start_n;
      mode_err   <= mode_err_n;
      busy       <= busy_n;
    end
  end

`ifdef STRASSEN_MM_WDOG_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_cnt <= '0;
      clr_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wd_cnt <= wd_cnt_n;
      clr_q  <= clr_n;
      err_q  <= err_n;
    end
  end
  assign mm_clr = clr_q;
  assign err    = err_q;
`else
  assign mm_clr = 1'b0;
  assign err    = 1'b0;
`endif

  assign fsm_state = state;

endmodule
